rf_banked_sb: RTL
=================

Name: rf_banked_sb

Overview:
- Next-generation CPU general register file: 16 architectural GPRs, R0–R7 shadowed by a second bank.
- Adds parametrised read/write port counts and same-cycle write-to-read bypass.
- Adds a per-physical-register load scoreboard for pipeline interlock.
- Adds a self-running reset initialisation sweep, so direct boot needs no build-time define.
- Sits between decode (read ports, scoreboard set) and writeback (write ports) in the SH-4 integer pipeline.

Parameters:
- NRD, 4, number of read ports.
- NWR, 2, number of write ports.
- DW, 32, data width.
- INIT_R15, 32'h8D000000, bank-0 R15 value written by the init sweep; all other registers are initialised to 0.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_src  in  NRD*4  architectural source index per read port (port i = bits [4i+3:4i]).
- rd_bank  in  NRD  bank select per read port.
- rd_data  out  NRD*DW  read data per port, combinational.
- rd_busy  out  NRD  per read port, 1 = source register has a pending scoreboard entry.
- wr_en  in  NWR  write enable per write port.
- wr_dst  in  NWR*4  destination index per write port.
- wr_bank  in  NWR  bank select per write port.
- wr_data  in  NWR*DW  write data per port.
- sb_set  in  1  mark a register pending (load issued).
- sb_dst  in  4  architectural index for sb_set.
- sb_bank  in  1  bank for sb_set.
- init_busy  out  1  initialisation sweep in progress.
- r0_out  out  DW  R0 of the bank selected by rd_bank[0], bypass applied.

Behaviour:
- Physical mapping (phys 0..23):
  - idx[3]=1 -> phys = idx.
  - idx[3]=0 and bank=1 -> phys = 16 + idx[2:0].
  - otherwise -> phys = idx.
  - The same mapping applies to reads, writes and sb_set.
- Reset and init sweep:
  - While rst=1: scoreboard cleared to 0, sweep counter set to 0, init_busy=1.
  - After rst deasserts: one physical entry is written per cycle, phys 0..23 in order. Entry 15 gets INIT_R15; all others get 0.
  - init_busy falls in the cycle after phys 23 is written, i.e. 24 cycles after rst deasserts.
  - rst reasserted mid-sweep restarts the sweep from phys 0.
- During init_busy=1:
  - wr_en and sb_set are ignored.
  - rd_data, r0_out and rd_busy read as 0.
- Writes:
  - Registered on the clk edge.
  - If two write ports hit the same phys, the highest-numbered port wins.
- Reads:
  - Zero latency.
  - If any wr_en port targets the same phys as a read in the same cycle, rd_data returns that port's wr_data (highest matching port wins); otherwise it returns the array content.
- Scoreboard, 24 bits:
  - sb_set sets the bit at its phys.
  - Any accepted write clears the bit at its phys.
  - sb_set and a write to the same phys in the same cycle: bit ends set, because the newer load wins.
  - rd_busy[i] = registered bit at the mapped phys, masked to 0 when a same-cycle write to that phys is being bypassed, unless sb_set also targets that phys in that cycle.
- Bank-0 R8–R15 are shared regardless of bank select.

Decomposition:
- rf_pkg holds: RF_NPHYS=24, RF_PW=5, phys-map function (idx, bank) -> phys, and the INIT_R15 default constant.
- One sub-module, rf_init_seq: sweep counter plus init_busy flag. Outputs init write enable, phys index and data, muxed ahead of the user write ports.

Test Plan:
- Reset 1 cycle, release -> init_busy=1 for exactly 24 cycles. Then read R15 bank0 = 8D000000; R0 bank0 = 0; R3 bank1 = 0.
- After init: write R5 bank1 = 0xDEADBEEF. Read R5 bank0 -> 0 and R5 bank1 -> DEADBEEF. Write R10 bank1 = 0x1234, then read R10 bank0 -> 0x1234 (shared).
- Same cycle: wr port0 R2 = 0x11 and port1 R2 = 0x22, with rd port3 reading R2 -> rd_data3 = 0x22 that cycle; array holds 0x22 the next cycle.
- sb_set R4 bank0 -> rd_busy=1 reading R4 next cycle. Write R4 = 0x55 -> rd_busy=0 that cycle with bypass data 0x55, and bit clear afterwards. sb_set plus write to R4 together -> bit stays set.
- rst asserted at sweep step 10 -> counter restarts and init_busy lasts 24 cycles from release. A wr_en during the sweep has no effect: target reads 0 after init.
- r0_out tracks bank via rd_bank[0]: write R0 bank1 = 0xA, bank0 = 0xB -> r0_out = 0xA with rd_bank[0]=1, 0xB with rd_bank[0]=0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants, types and the architectural-to-physical register mapping
// for the banked register file.
package rf_pkg;
  localparam int          RF_NPHYS    = 24;
  localparam int          RF_PW       = 5;
  localparam logic [31:0] RF_INIT_R15 = 32'h8D00_0000;

  typedef logic [RF_PW-1:0] phys_t;

  typedef struct packed {
    logic  we;
    phys_t phys;
  } rf_wsel_t;

  // R0-R7 of bank 1 live at phys 16..23; R8-R15 are shared by both banks.
  function automatic phys_t rf_phys(input logic [3:0] idx, input logic bank);
    if (bank && !idx[3]) return {2'b10, idx[2:0]};
    return {1'b0, idx};
  endfunction
endpackage

// File: rtl/rf_banked_sb_if.sv
// Decode/writeback-facing bus of the banked register file.
interface rf_banked_sb_if #(
  parameter int NRD = 4,
  parameter int NWR = 2,
  parameter int DW  = 32
);
  logic [NRD*4-1:0]  rd_src;
  logic [NRD-1:0]    rd_bank;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*4-1:0]  wr_dst;
  logic [NWR-1:0]    wr_bank;
  logic [NWR*DW-1:0] wr_data;
  logic              sb_set;
  logic [3:0]        sb_dst;
  logic              sb_bank;
  logic              init_busy;
  logic [DW-1:0]     r0_out;

  modport master (
    output rd_src, rd_bank, wr_en, wr_dst, wr_bank, wr_data, sb_set, sb_dst, sb_bank,
    input  rd_data, rd_busy, init_busy, r0_out
  );
  modport slave (
    input  rd_src, rd_bank, wr_en, wr_dst, wr_bank, wr_data, sb_set, sb_dst, sb_bank,
    output rd_data, rd_busy, init_busy, r0_out
  );
endinterface

// File: rtl/rf_init_seq.sv
// Post-reset sweep: writes one physical entry per cycle so boot needs no preset array.
module rf_init_seq
  import rf_pkg::*;
#(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] INIT_R15 = DW'(RF_INIT_R15)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_we_o,
  output phys_t         init_idx_o,
  output logic [DW-1:0] init_data_o,
  output logic          busy_o
);
  phys_t cnt_q, cnt_d;
  logic  busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      if (cnt_q == phys_t'(RF_NPHYS - 1)) busy_d = 1'b0;
      else                                cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign init_we_o   = busy_q;
  assign init_idx_o  = cnt_q;
  assign init_data_o = (cnt_q == phys_t'(15)) ? INIT_R15 : '0;
  assign busy_o      = busy_q;
endmodule

// File: rtl/rf_banked_sb.sv
// Banked 16-GPR register file with write-to-read bypass and a load scoreboard.
module rf_banked_sb
  import rf_pkg::*;
#(
  parameter int            NRD      = 4,
  parameter int            NWR      = 2,
  parameter int            DW       = 32,
  parameter logic [DW-1:0] INIT_R15 = DW'(RF_INIT_R15)
) (
  input  logic           clk,
  input  logic           rst,
  rf_banked_sb_if.slave  bus
);
  logic          init_we, seq_busy, init_busy;
  phys_t         init_idx;
  logic [DW-1:0] init_data;

  rf_init_seq #(.DW(DW), .INIT_R15(INIT_R15)) u_init (
    .clk         (clk),
    .rst         (rst),
    .init_we_o   (init_we),
    .init_idx_o  (init_idx),
    .init_data_o (init_data),
    .busy_o      (seq_busy)
  );

  assign init_busy     = rst | seq_busy;
  assign bus.init_busy = init_busy;

  rf_wsel_t [NWR-1:0] wsel;
  logic               sb_we;
  phys_t              sb_phys;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wsel[w].we   = bus.wr_en[w] & ~init_busy;
      wsel[w].phys = rf_phys(bus.wr_dst[4*w +: 4], bus.wr_bank[w]);
    end
  end

  assign sb_we   = bus.sb_set & ~init_busy;
  assign sb_phys = rf_phys(bus.sb_dst, bus.sb_bank);

  logic [DW-1:0]       regs_q [RF_NPHYS];
  logic [RF_NPHYS-1:0] sb_q, sb_d;

  // Ascending port order lets the highest-numbered port win a collision.
  always_ff @(posedge clk) begin
    if (init_we) regs_q[init_idx] <= init_data;
    else begin
      for (int w = 0; w < NWR; w++)
        if (wsel[w].we) regs_q[wsel[w].phys] <= bus.wr_data[DW*w +: DW];
    end
  end

  // Set is applied after clears: a new load outranks the older writeback.
  always_comb begin
    sb_d = sb_q;
    for (int w = 0; w < NWR; w++)
      if (wsel[w].we) sb_d[wsel[w].phys] = 1'b0;
    if (sb_we) sb_d[sb_phys] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  // Lane NRD is the dedicated R0 tap steered by rd_bank[0].
  logic [NRD:0][3:0]    lsrc;
  logic [NRD:0]         lbank;
  logic [NRD:0][DW-1:0] ldata;
  logic [NRD-1:0]       lbusy;

  for (genvar i = 0; i <= NRD; i++) begin : g_rd
    phys_t         p;
    logic [DW-1:0] d;
    logic          byp;

    assign lsrc[i]  = (i < NRD) ? bus.rd_src[4*(i % NRD) +: 4] : 4'd0;
    assign lbank[i] = bus.rd_bank[i % NRD];
    assign p        = rf_phys(lsrc[i], lbank[i]);

    always_comb begin
      d   = regs_q[p];
      byp = 1'b0;
      for (int w = 0; w < NWR; w++) begin
        if (wsel[w].we && wsel[w].phys == p) begin
          d   = bus.wr_data[DW*w +: DW];
          byp = 1'b1;
        end
      end
      if (init_busy) d = '0;
    end

    assign ldata[i] = d;

    if (i < NRD) begin : g_busy
      assign lbusy[i] = ~init_busy & sb_q[p] & (~byp | (sb_we & (sb_phys == p)));
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_out
    assign bus.rd_data[DW*i +: DW] = ldata[i];
  end

  assign bus.rd_busy = lbusy;
  assign bus.r0_out  = ldata[NRD];
endmodule
